// File: rtl/inst_aligner.sv
// inst_aligner: turns word-aligned fetch data into a stream of RV32IC
// instructions with PCs, splitting compressed pairs and stitching spans.
module inst_aligner #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    input  logic [31:0] flush_pc_in,
    output logic        fetch_req_out,
    output logic [31:0] fetch_addr_out,
    input  logic        fetch_valid_in,
    input  logic [31:0] fetch_data_in,
    output logic        inst_valid_out,
    input  logic        inst_ready_in,
    output logic [31:0] inst_out,
    output logic [31:0] inst_pc_out,
    output logic        inst_is_c_out
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        EMIT = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nx;

    logic [31:1] pc;
    logic [31:0] word_buf;
    logic [15:0] span_half;
    logic        span_pend;
    logic [31:0] fetch_addr;

    logic        lo_c;
    logic        hi_c;
    logic        cand_valid;
    logic [31:0] cand_inst;
    logic        cand_c;
    logic        emit_valid;
    logic        accept;
    logic        stay;
    logic        leave;
    logic        stall_span;

    // Bit 0 of any PC is architecturally zero and is dropped on purpose.
    logic        unused_bits;
    assign unused_bits = flush_pc_in[0];

    assign lo_c = (word_buf[1:0] != 2'b11);
    assign hi_c = (word_buf[17:16] != 2'b11);

    // Pick the instruction at pc out of the buffered word (and span half).
    always_comb begin
        cand_valid = 1'b0;
        cand_inst  = 32'h0;
        cand_c     = 1'b0;
        if (span_pend) begin
            cand_valid = 1'b1;
            cand_inst  = {word_buf[15:0], span_half};
        end else if (!pc[1]) begin
            cand_valid = 1'b1;
            if (lo_c) begin
                cand_c    = 1'b1;
                cand_inst = {16'h0, word_buf[15:0]};
            end else begin
                cand_inst = word_buf;
            end
        end else if (hi_c) begin
            cand_valid = 1'b1;
            cand_c     = 1'b1;
            cand_inst  = {16'h0, word_buf[31:16]};
        end
    end

    assign emit_valid = (state == EMIT) && cand_valid;
    assign accept     = emit_valid && inst_ready_in;
    assign stall_span = (state == EMIT) && !cand_valid;
    // Stay on the same word after a span or a low compressed half.
    assign stay       = accept && (span_pend || (!pc[1] && cand_c));
    assign leave      = accept && !stay;

    // State register.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; a flush always returns to IDLE.
    always_comb begin
        state_nx = state;
        if (flush_in) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    state_nx = REQ;
                REQ:     if (fetch_valid_in) state_nx = EMIT;
                EMIT:    if (stall_span || leave) state_nx = REQ;
                default: state_nx = IDLE;
            endcase
        end
    end

    // Output decode from the current state and buffered data.
    always_comb begin
        fetch_req_out  = (state == REQ);
        fetch_addr_out = fetch_addr;
        inst_valid_out = emit_valid;
        inst_out       = emit_valid ? cand_inst : 32'h0;
        inst_is_c_out  = emit_valid && cand_c;
        inst_pc_out    = {pc, 1'b0};
    end

    // PC, fetch address, word buffer and span bookkeeping.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pc         <= RESET_PC[31:1];
            word_buf   <= 32'h0;
            span_half  <= 16'h0;
            span_pend  <= 1'b0;
            fetch_addr <= {RESET_PC[31:2], 2'b00};
        end else if (flush_in) begin
            pc         <= flush_pc_in[31:1];
            span_pend  <= 1'b0;
            fetch_addr <= {flush_pc_in[31:2], 2'b00};
        end else begin
            case (state)
                IDLE: begin
                    fetch_addr <= {pc[31:2], 2'b00};
                end
                REQ: begin
                    if (fetch_valid_in) begin
                        word_buf <= fetch_data_in;
                    end
                end
                EMIT: begin
                    if (stall_span) begin
                        span_half  <= word_buf[31:16];
                        span_pend  <= 1'b1;
                        fetch_addr <= fetch_addr + 32'd4;
                    end else if (accept) begin
                        if (span_pend) begin
                            pc        <= pc + 31'd2;
                            span_pend <= 1'b0;
                        end else if (stay) begin
                            pc <= pc + 31'd1;
                        end else begin
                            pc <= pc + (pc[1] ? 31'd1 : 31'd2);
                        end
                        if (leave) begin
                            fetch_addr <= fetch_addr + 32'd4;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_aligner.sv
// tb_inst_aligner: directed checks of fetch sequencing, splitting,
// span stitching, back-pressure, flush and reset for inst_aligner.
module tb_inst_aligner;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] flush_pc = 32'h0;
    logic        fetch_req;
    logic [31:0] fetch_addr;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_is_c;

    int checks = 0;
    int errors = 0;

    inst_aligner #(.RESET_PC(32'h0)) dut (
        .clk_in(clk),
        .rst_in(rst),
        .flush_in(flush),
        .flush_pc_in(flush_pc),
        .fetch_req_out(fetch_req),
        .fetch_addr_out(fetch_addr),
        .fetch_valid_in(fetch_valid),
        .fetch_data_in(fetch_data),
        .inst_valid_out(inst_valid),
        .inst_ready_in(inst_ready),
        .inst_out(inst),
        .inst_pc_out(inst_pc),
        .inst_is_c_out(inst_is_c)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for a request, check its address, hold one cycle,
    // then return the word; the emit becomes visible at the next negedge.
    task automatic serve(input logic [31:0] addr, input logic [31:0] data);
        int n = 0;
        while (!fetch_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", {31'h0, fetch_req}, 32'h1);
        chk("fetch_addr", fetch_addr, addr);
        @(negedge clk);
        chk("addr_hold", fetch_addr, addr);
        fetch_valid = 1'b1;
        fetch_data  = data;
        @(negedge clk);
        fetch_valid = 1'b0;
        fetch_data  = 32'h0;
    endtask

    task automatic emit(input string tag, input logic [31:0] e_inst,
                        input logic [31:0] e_pc, input logic e_c);
        chk({tag, "_valid"}, {31'h0, inst_valid}, 32'h1);
        chk({tag, "_inst"}, inst, e_inst);
        chk({tag, "_pc"}, inst_pc, e_pc);
        chk({tag, "_is_c"}, {31'h0, inst_is_c}, {31'h0, e_c});
        @(negedge clk);
    endtask

    task automatic do_flush(input logic [31:0] pc);
        flush    = 1'b1;
        flush_pc = pc;
        @(negedge clk);
        flush    = 1'b0;
    endtask

    initial begin
        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_req", {31'h0, fetch_req}, 32'h0);
        chk("rst_addr", fetch_addr, 32'h0);
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst, 32'h0);
        chk("rst_pc", inst_pc, 32'h0);
        chk("rst_is_c", {31'h0, inst_is_c}, 32'h0);
        rst = 1'b0;

        // Single 32-bit instruction
        serve(32'h0, 32'h0013_0093);
        emit("addi", 32'h0013_0093, 32'h0, 1'b0);
        chk("next_req", {31'h0, fetch_req}, 32'h1);
        chk("next_addr", fetch_addr, 32'h4);
        chk("next_nov", {31'h0, inst_valid}, 32'h0);

        // Two compressed back-to-back
        do_flush(32'h0);
        serve(32'h0, 32'h4501_4505);
        emit("cli0", 32'h0000_4505, 32'h0, 1'b1);
        emit("cli1", 32'h0000_4501, 32'h2, 1'b1);
        chk("pair_nov", {31'h0, inst_valid}, 32'h0);
        chk("pair_addr", fetch_addr, 32'h4);

        // Straddling instruction
        do_flush(32'h0);
        serve(32'h0, 32'h0093_4505);
        emit("sp_c", 32'h0000_4505, 32'h0, 1'b1);
        chk("bubble", {31'h0, inst_valid}, 32'h0);
        serve(32'h4, 32'hABCD_0013);
        emit("span", 32'h0013_0093, 32'h2, 1'b0);
        emit("sp_hi", 32'h0000_ABCD, 32'h6, 1'b1);
        chk("sp_addr", fetch_addr, 32'h8);

        // Back-pressure for 5 cycles
        inst_ready = 1'b0;
        do_flush(32'h10);
        serve(32'h10, 32'h4501_4505);
        for (int i = 0; i < 5; i++) begin
            chk("hold_valid", {31'h0, inst_valid}, 32'h1);
            chk("hold_inst", inst, 32'h0000_4505);
            chk("hold_pc", inst_pc, 32'h10);
            chk("hold_noreq", {31'h0, fetch_req}, 32'h0);
            @(negedge clk);
        end
        inst_ready = 1'b1;
        emit("rel0", 32'h0000_4505, 32'h10, 1'b1);
        emit("rel1", 32'h0000_4501, 32'h12, 1'b1);

        // Flush while a span is pending
        do_flush(32'h20);
        serve(32'h20, 32'h0093_4505);
        emit("fs_c", 32'h0000_4505, 32'h20, 1'b1);
        chk("fs_bub", {31'h0, inst_valid}, 32'h0);
        @(negedge clk);
        chk("fs_pend_addr", fetch_addr, 32'h24);
        do_flush(32'h102);
        serve(32'h100, 32'h4501_0093);
        emit("fs_hi", 32'h0000_4501, 32'h102, 1'b1);
        chk("fs_next", fetch_addr, 32'h104);

        // Fetch data coinciding with flush is dropped
        flush       = 1'b1;
        flush_pc    = 32'h200;
        fetch_valid = 1'b1;
        fetch_data  = 32'h0000_0013;
        @(negedge clk);
        flush       = 1'b0;
        fetch_valid = 1'b0;
        chk("fv_nov", {31'h0, inst_valid}, 32'h0);
        chk("fv_noreq", {31'h0, fetch_req}, 32'h0);
        @(negedge clk);
        chk("fv_nov2", {31'h0, inst_valid}, 32'h0);
        serve(32'h200, 32'h4505_4505);
        chk("fv_pc", inst_pc, 32'h200);

        // Flush and accept in the same cycle
        chk("fa_valid", {31'h0, inst_valid}, 32'h1);
        do_flush(32'h300);
        chk("fa_nov", {31'h0, inst_valid}, 32'h0);
        serve(32'h300, 32'h0013_0093);
        emit("fa", 32'h0013_0093, 32'h300, 1'b0);

        // Address wrap
        do_flush(32'hFFFF_FFFC);
        serve(32'hFFFF_FFFC, 32'h0013_0093);
        emit("wrap", 32'h0013_0093, 32'hFFFF_FFFC, 1'b0);
        chk("wrap_addr", fetch_addr, 32'h0);

        // Reset mid-span
        do_flush(32'h40);
        serve(32'h40, 32'h0093_4505);
        emit("rs_c", 32'h0000_4505, 32'h40, 1'b1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rs_req", {31'h0, fetch_req}, 32'h0);
        chk("rs_addr", fetch_addr, 32'h0);
        chk("rs_pc", inst_pc, 32'h0);
        chk("rs_valid", {31'h0, inst_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        serve(32'h0, 32'h4501_4505);
        emit("rs_post", 32'h0000_4505, 32'h0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/inst_aligner.md
# inst_aligner

Fetch-side sequencer that turns a stream of word-aligned 32-bit memory words into a stream of individual RV32IC instructions with their PCs. It tracks the halfword position of the PC, issues word fetches, splits words holding compressed instructions, and stitches 32-bit instructions that straddle a word boundary. It sits between the instruction memory/cache port and the decompression stage: every emitted 16-bit instruction is presented zero-extended with a compressed flag, ready to drive `inst_c` of the decompressor.

## Interface
- RESET_PC, 32'h0000_0000, PC loaded on reset; bit 0 ignored.
- clk_in  input  1  clock; all state updates on rising edge
- rst_in  input  1  reset, asynchronous, active-high
- flush_in  input  1  redirect request; highest priority
- flush_pc_in  input  32  new PC on flush; bit 0 treated as 0
- fetch_req_out  output  1  word fetch request, registered
- fetch_addr_out  output  32  word address of request, bits [1:0] always 00
- fetch_valid_in  input  1  one-cycle pulse: fetch_data_in holds word at fetch_addr_out
- fetch_data_in  input  32  fetched word, little-endian halfwords
- inst_valid_out  output  1  instruction available
- inst_ready_in  input  1  consumer accepts instruction this cycle
- inst_out  output  32  raw instruction; compressed → {16'h0, half}
- inst_pc_out  output  32  PC of inst_out
- inst_is_c_out  output  1  1 when inst_out is a 16-bit instruction

## Operation
- Registers: pc[31:1], word_buf[31:0], span_half[15:0], span_pend, state ∈ {IDLE, REQ, EMIT}.
- Compressed test on a halfword h: compressed iff h[1:0] != 2'b11.
- IDLE: next cycle → REQ with fetch_addr = {pc[31:2],2'b00}.
- REQ: fetch_req_out=1, address held stable until fetch_valid_in. On fetch_valid_in: word_buf ← data; → EMIT.
- EMIT candidate selection:
  - span_pend=1: inst = {word_buf[15:0], span_half}, 32-bit, PC = pc (pc[1]=1).
  - pc[1]=0, word_buf[15:0] compressed: 16-bit inst = word_buf[15:0].
  - pc[1]=0, not compressed: 32-bit inst = word_buf.
  - pc[1]=1, word_buf[31:16] compressed: 16-bit inst = word_buf[31:16].
  - pc[1]=1, not compressed, span_pend=0: no emit; span_half ← word_buf[31:16], span_pend ← 1, fetch addr += 4, → REQ (one bubble cycle, inst_valid_out=0).
- EMIT accept (inst_valid_out & inst_ready_in):
  - span case: pc += 4, span_pend ← 0, stay EMIT (upper half of word_buf is next candidate).
  - 16-bit at pc[1]=0: pc += 2, stay EMIT.
  - 32-bit at pc[1]=0 or 16-bit at pc[1]=1: pc advances to next word, fetch addr += 4, → REQ.
- inst_valid_out = 1 only in EMIT with a valid candidate; outputs stable while valid & !ready.
- Flush (any state): pc ← flush_pc_in, span_pend ← 0, state ← IDLE, fetch_req_out ← 0 next cycle; fetch_valid_in in the flush cycle is ignored. Memory side must drop an in-flight request when fetch_req_out deasserts.
- Address arithmetic wraps modulo 2^32 (0xFFFF_FFFC + 4 → 0x0000_0000).

## Timing
- Reset values: state=IDLE, pc=RESET_PC, span_pend=0, fetch_req_out=0, fetch_addr_out={RESET_PC[31:2],2'b00}, inst_valid_out=0, inst_out=0, inst_pc_out=RESET_PC, inst_is_c_out=0.
- Reset release at edge N: fetch_req_out=1 from edge N+1.
- fetch_valid_in at edge N → inst_valid_out=1 after edge N (visible cycle N+1).
- Two compressed instructions in one word: back-to-back, one per cycle with ready held high.
- Straddling instruction: 1 bubble + fetch latency before emit.
- Flush and accept in same cycle: flush wins, accept has no effect on pc.
- Reset asserted mid-fetch or mid-span: all state returns to reset values immediately.

## Test plan
- Reset, RESET_PC=0, memory word0=0x00130093 (addi) → fetch_addr_out=0, emit inst_out=0x00130093, pc 0, is_c=0; next fetch_addr_out=4.
- word0=0x4501_4505 (two c.li), ready high → emit 0x00004505 @pc0 then 0x00004501 @pc2 on consecutive cycles, is_c=1; then fetch addr 4.
- word0=0x0093_4505, word1=0xXXXX_0013 → emit c @0, then fetch 4, emit 0x00130093 @pc2 is_c=0, then 0xXXXX half @pc6.
- Hold inst_ready_in=0 for 5 cycles with valid → inst_out/inst_pc_out unchanged, pc unchanged, no new fetch.
- flush_in with flush_pc_in=0x102 while span pending → span dropped, next fetch_addr_out=0x100, first emit uses upper half at pc 0x102.
- fetch_valid_in coinciding with flush_in → data discarded, no inst_valid_out until re-fetch at flushed address completes.
